iota_round_stage: RTL and testbench

Registered iota step of the Keccak-f[1600] permutation, placed directly downstream of the combinational chi step. Each accepted 25-lane state has the round constant for the current round XORed into lane 0, then is held in an output register with a valid/ready handshake. The block owns the round counter, the round-constant generation and the last-round flag that the permutation controller uses to stop iterating.

---
 rtl/iota_round_stage_if.sv | 22 ++
 rtl/iota_round_stage.sv | 79 +++++++
 tb/tb_iota_round_stage.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/iota_round_stage_if.sv
// Handshake bundle for iota_round_stage: chi-side input stream and the
// round-tagged output stream toward the permutation controller.
interface iota_round_stage_if;
  logic              in_valid;
  logic              in_ready;
  logic [0:24][63:0] state_in;
  logic              out_valid;
  logic              out_ready;
  logic [0:24][63:0] state_out;
  logic [4:0]        round_out;
  logic              last_round;

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out, round_out, last_round
  );

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out, round_out, last_round
  );
endinterface

// File: rtl/iota_round_stage.sv
// Registered Keccak-f[1600] iota step: XORs RC[round] into lane 0, tracks the
// round counter and flags the last round of the permutation.
module iota_round_stage #(
  parameter int unsigned NUM_ROUNDS = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  iota_round_stage_if.slave  bus
);

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);
  localparam logic [7:0] LFSR_SEED  = 8'h01;

  logic [4:0]        round_cnt;
  logic [7:0]        lfsr;
  logic [7:0]        walk [0:7];
  logic [6:0]        rc_bits;
  logic [63:0]       rc;
  logic [0:24][63:0] iota_state;
  logic              accept;
  logic              wrap;

  // One step of the rc(t) LFSR, x^8+x^6+x^5+x^4+1, bit 0 is the output bit.
  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ ({8{r[7]}} & 8'h71);
  endfunction

  // lfsr holds the LFSR state at t = 7*round_cnt; walking it seven steps
  // yields the round's seven constant bits and the state for the next round.
  assign walk[0] = lfsr;
  for (genvar g = 0; g < 7; g++) begin : g_walk
    assign walk[g+1]  = lfsr_step(walk[g]);
    assign rc_bits[g] = walk[g][0];
  end

  assign rc = {rc_bits[6], 31'b0, rc_bits[5], 15'b0, rc_bits[4], 7'b0,
               rc_bits[3], 3'b0, rc_bits[2], 1'b0, rc_bits[1], rc_bits[0]};

  assign iota_state   = {bus.state_in[0] ^ rc, bus.state_in[1:24]};
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !clear;
  assign wrap         = (round_cnt == LAST_ROUND);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      round_cnt     <= '0;
      lfsr          <= LFSR_SEED;
      bus.out_valid <= 1'b0;
    end else if (clear) begin
      round_cnt     <= '0;
      lfsr          <= LFSR_SEED;
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      round_cnt     <= wrap ? 5'd0 : round_cnt + 5'd1;
      lfsr          <= wrap ? LFSR_SEED : walk[7];
      bus.out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

  // NOTE: the wide data register is reset because the consumer may observe
  // state_out while out_valid is low; it is deliberately left untouched on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.state_out  <= '0;
      bus.round_out  <= '0;
      bus.last_round <= 1'b0;
    end else if (accept) begin
      bus.state_out  <= iota_state;
      bus.round_out  <= round_cnt;
      bus.last_round <= wrap;
    end
  end

endmodule

// File: tb/tb_iota_round_stage.sv
// Self-checking bench for iota_round_stage: directed scenarios plus a random
// phase checked against a transaction-level model using FIPS 202 rc(t).
module tb_iota_round_stage;

  typedef logic [0:24][63:0] lanes_t;
  localparam int NR = 24;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic clear   = 1'b0;
  logic clear12 = 1'b0;

  int checks = 0;
  int errors = 0;

  lanes_t m_state = '0;
  int     m_round = 0;
  int     m_out_round = 0;
  bit     m_valid = 1'b0;
  bit     m_last = 1'b0;

  iota_round_stage_if bus ();
  iota_round_stage_if bus12 ();

  iota_round_stage #(.NUM_ROUNDS(24)) dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus.slave)
  );

  iota_round_stage #(.NUM_ROUNDS(12)) dut12 (
    .clk(clk), .rst(rst), .clear(clear12), .bus(bus12.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // rc(t) exactly as FIPS 202 Algorithm 5, recomputed from t = 0 each call.
  function automatic bit rc_bit(input int t);
    bit [8:0] r;
    r = 9'h001;
    for (int k = 0; k < t % 255; k++) begin
      r = r << 1;
      if (r[8]) r = r ^ 9'h171;
    end
    return r[0];
  endfunction

  function automatic logic [63:0] ref_rc(input int i);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < 7; j++) v = v | (64'(rc_bit(j + 7 * i)) << ((1 << j) - 1));
    return v;
  endfunction

  function automatic lanes_t rand_state();
    lanes_t s;
    s = '0;
    for (int k = 0; k < 25; k++) s = {s[1:24], {$urandom, $urandom}};
    return s;
  endfunction

  function automatic lanes_t pattern_state();
    lanes_t s;
    s = '0;
    for (int k = 0; k < 25; k++) s = {s[1:24], {8{k[7:0]}}};
    return s;
  endfunction

  task automatic compare_outputs();
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    check("round_out", 64'(bus.round_out), 64'(m_out_round));
    check("last_round", 64'(bus.last_round), 64'(m_last));
    for (logic [4:0] k = 5'd0; k <= 5'd24; k++)
      check($sformatf("lane%0d", k), bus.state_out[k], m_state[k]);
  endtask

  // Drive one cycle of stimulus, advance the model, check after the edge.
  task automatic cycle(input bit v, input lanes_t s, input bit ordy, input bit clr);
    bus.in_valid  = v;
    bus.state_in  = s;
    bus.out_ready = ordy;
    clear         = clr;
    #1;
    check("in_ready", 64'(bus.in_ready), 64'(!m_valid || ordy));
    if (clr) begin
      m_round = 0;
      m_valid = 1'b0;
    end else if (v && (!m_valid || ordy)) begin
      m_state     = s;
      m_state[0]  = s[0] ^ ref_rc(m_round);
      m_out_round = m_round;
      m_last      = (m_round == NR - 1);
      m_valid     = 1'b1;
      m_round     = (m_round + 1) % NR;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    lanes_t s1;
    lanes_t s2;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b1;
    bus.state_in    = '0;
    bus12.in_valid  = 1'b0;
    bus12.out_ready = 1'b1;
    bus12.state_in  = '0;

    // Reset values, then release
    @(negedge clk);
    compare_outputs();
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

    // 24 back-to-back zero states plus a 25th that wraps to RC[0]
    for (int i = 0; i < 25; i++) begin
      cycle(1'b1, '0, 1'b1, 1'b0);
      case (i)
        0:  check("rc0_const", bus.state_out[0], 64'h0000000000000001);
        1:  check("rc1_const", bus.state_out[0], 64'h0000000000008082);
        2:  check("rc2_const", bus.state_out[0], 64'h800000000000808A);
        3:  check("rc3_const", bus.state_out[0], 64'h8000000080008000);
        23: check("rc23_const", bus.state_out[0], 64'h8000000080008008);
        24: check("wrap_rc0", bus.state_out[0], 64'h0000000000000001);
        default: ;
      endcase
    end

    // Lane pattern at round 1
    cycle(1'b1, pattern_state(), 1'b1, 1'b0);
    check("pattern_lane0", bus.state_out[0], 64'h0000000000008082);
    check("pattern_lane7", bus.state_out[7], {8{8'h07}});
    cycle(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: hold round-0 output for 3 cycles with a pending input
    cycle(1'b0, '0, 1'b1, 1'b1);
    s1 = rand_state();
    s2 = rand_state();
    cycle(1'b1, s1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, s2, 1'b0, 1'b0);
    cycle(1'b1, s2, 1'b1, 1'b0);
    check("bp_next_rc1", bus.state_out[0], s2[0] ^ 64'h8082);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // clear after 5 accepts with a simultaneous in_valid
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, rand_state(), 1'b1, 1'b0);
    cycle(1'b1, rand_state(), 1'b1, 1'b1);
    check("clear_drops", 64'(bus.out_valid), 64'd0);
    s1 = rand_state();
    cycle(1'b1, s1, 1'b1, 1'b0);
    check("after_clear_round", 64'(bus.round_out), 64'd0);
    check("after_clear_lane0", bus.state_out[0], s1[0] ^ 64'h1);

    // Asynchronous rst mid-cycle while round 10 is on the output
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) cycle(1'b1, rand_state(), 1'b1, 1'b0);
    check("pre_rst_round10", 64'(bus.round_out), 64'd10);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_state = '0;  m_round = 0;  m_out_round = 0;  m_valid = 1'b0;  m_last = 1'b0;
    compare_outputs();
    @(negedge clk);
    rst = 1'b0;
    s1 = rand_state();
    cycle(1'b1, s1, 1'b1, 1'b0);
    check("after_rst_lane0", bus.state_out[0], s1[0] ^ 64'h1);

    // Random traffic with backpressure and occasional clear
    for (int i = 0; i < 80; i++)
      cycle(($urandom % 4) != 0, rand_state(), ($urandom % 3) != 0, ($urandom % 16) == 0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    // NUM_ROUNDS=12 instance: last_round on the 12th output, then wrap
    bus12.in_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      check("nr12_valid", 64'(bus12.out_valid), 64'd1);
      check("nr12_round", 64'(bus12.round_out), 64'(i % 12));
      check("nr12_last", 64'(bus12.last_round), 64'((i % 12) == 11));
      check("nr12_lane0", bus12.state_out[0], ref_rc(i % 12));
    end
    bus12.in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
